// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the D/E stages and stall/flush/perf outputs to the pipeline
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              i_mem_stall;
    logic              i_e_mc_start;
    logic              i_e_redirect;
    logic              i_e_is_load;
    logic [REG_AW-1:0] i_e_rd;
    logic [REG_AW-1:0] i_d_rs1;
    logic [REG_AW-1:0] i_d_rs2;
    logic              i_d_use_rs1;
    logic              i_d_use_rs2;
    logic              o_pc_en;
    logic              o_en_fd;
    logic              o_en_de;
    logic              o_en_em;
    logic              o_flush_fd;
    logic              o_flush_de;
    logic              o_flush_em;
    logic              o_mc_busy;
    logic [CNT_W-1:0]  o_perf_stall;
    logic [CNT_W-1:0]  o_perf_flush;

    modport master (
        output i_mem_stall, i_e_mc_start, i_e_redirect, i_e_is_load, i_e_rd,
               i_d_rs1, i_d_rs2, i_d_use_rs1, i_d_use_rs2,
        input  o_pc_en, o_en_fd, o_en_de, o_en_em, o_flush_fd, o_flush_de, o_flush_em,
               o_mc_busy, o_perf_stall, o_perf_flush
    );

    modport slave (
        input  i_mem_stall, i_e_mc_start, i_e_redirect, i_e_is_load, i_e_rd,
               i_d_rs1, i_d_rs2, i_d_use_rs1, i_d_use_rs2,
        output o_pc_en, o_en_fd, o_en_de, o_en_em, o_flush_fd, o_flush_de, o_flush_em,
               o_mc_busy, o_perf_stall, o_perf_flush
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the F/D, D/E and E/M registers and the PC
module pipe_hazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input logic               clk,
    input logic               n_rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int MCW = $clog2(MC_LAT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [MCW-1:0]    mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0]  perf_stall_q, perf_stall_d;
    logic [CNT_W-1:0]  perf_flush_q, perf_flush_d;
    logic [REG_AW-1:0] e_rd;
    logic              mc_stall, load_use;
    logic [6:0]        ctl;

    assign e_rd     = bus.i_e_rd;
    assign mc_stall = (state_q == IDLE) ? bus.i_e_mc_start : (mc_cnt_q != '0);
    assign load_use = bus.i_e_is_load && (e_rd != '0) &&
                      ((bus.i_d_use_rs1 && bus.i_d_rs1 == e_rd) ||
                       (bus.i_d_use_rs2 && bus.i_d_rs2 == e_rd));

    // {pc_en, en_fd, en_de, en_em, flush_fd, flush_de, flush_em}
    assign ctl = (!n_rst || bus.i_mem_stall) ? 7'b0000000 :
                 mc_stall                    ? 7'b0001001 :
                 bus.i_e_redirect            ? 7'b1111110 :
                 load_use                    ? 7'b0011010 :
                                               7'b1111000;

    assign {bus.o_pc_en, bus.o_en_fd, bus.o_en_de, bus.o_en_em,
            bus.o_flush_fd, bus.o_flush_de, bus.o_flush_em} = ctl;
    assign bus.o_mc_busy    = n_rst && (state_q == BUSY);
    assign bus.o_perf_stall = perf_stall_q;
    assign bus.o_perf_flush = perf_flush_q;

    // mem_stall freezes the sequencer; BUSY with mc_cnt==0 is the release cycle
    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        if (!bus.i_mem_stall && state_q == IDLE && bus.i_e_mc_start) begin
            state_d  = BUSY;
            mc_cnt_d = MCW'(MC_LAT - 2);
        end else if (!bus.i_mem_stall && state_q == BUSY) begin
            mc_cnt_d = (mc_cnt_q != '0) ? mc_cnt_q - MCW'(1) : mc_cnt_q;
            state_d  = (mc_cnt_q != '0) ? BUSY : IDLE;
        end
        perf_stall_d = perf_stall_q + CNT_W'(!ctl[6] && !(&perf_stall_q));
        perf_flush_d = perf_flush_q + CNT_W'((|ctl[2:0]) && !(&perf_flush_q));
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            mc_cnt_q     <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            state_q      <= state_d;
            mc_cnt_q     <= mc_cnt_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus randomized run against an occupancy-based model
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic n_rst;
    logic mem, start, redir, isld, u1, u2;
    logic [4:0] erd, rs1, rs2;
    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) ifa ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  ifb ();

    pipe_hazard_ctrl #(.MC_LAT(4), .REG_AW(5), .CNT_W(32)) dut_a (.clk(clk), .n_rst(n_rst), .bus(ifa.slave));
    pipe_hazard_ctrl #(.MC_LAT(2), .REG_AW(5), .CNT_W(4))  dut_b (.clk(clk), .n_rst(n_rst), .bus(ifb.slave));

    assign ifa.i_mem_stall = mem;   assign ifb.i_mem_stall = mem;
    assign ifa.i_e_mc_start = start; assign ifb.i_e_mc_start = start;
    assign ifa.i_e_redirect = redir; assign ifb.i_e_redirect = redir;
    assign ifa.i_e_is_load = isld;  assign ifb.i_e_is_load = isld;
    assign ifa.i_e_rd = erd;        assign ifb.i_e_rd = erd;
    assign ifa.i_d_rs1 = rs1;       assign ifb.i_d_rs1 = rs1;
    assign ifa.i_d_rs2 = rs2;       assign ifb.i_d_rs2 = rs2;
    assign ifa.i_d_use_rs1 = u1;    assign ifb.i_d_use_rs1 = u1;
    assign ifa.i_d_use_rs2 = u2;    assign ifb.i_d_use_rs2 = u2;

    logic [7:0] out_a, out_b;
    assign out_a = {ifa.o_pc_en, ifa.o_en_fd, ifa.o_en_de, ifa.o_en_em,
                    ifa.o_flush_fd, ifa.o_flush_de, ifa.o_flush_em, ifa.o_mc_busy};
    assign out_b = {ifb.o_pc_en, ifb.o_en_fd, ifb.o_en_de, ifb.o_en_em,
                    ifb.o_flush_fd, ifb.o_flush_de, ifb.o_flush_em, ifb.o_mc_busy};

    // model: age = non-frozen cycles the current multi-cycle op has spent in E (0 = none)
    int lat[2] = '{4, 2};
    longint unsigned cmax[2] = '{64'hFFFF_FFFF, 64'd15};
    int age[2];
    longint unsigned pst[2], pfl[2];
    bit perf_ok = 0;

    function automatic logic [7:0] model_out(int k);
        logic busy, mcs, lu;
        busy = age[k] > 0;
        if (!n_rst) return 8'b0;
        if (mem) return {7'b0, busy};
        mcs = (age[k] == 0 && start) || (age[k] > 0 && age[k] < lat[k] - 1);
        lu = isld && erd != 0 && ((u1 && rs1 == erd) || (u2 && rs2 == erd));
        if (mcs) return {7'b0001001, busy};
        if (redir) return {7'b1111110, busy};
        if (lu) return {7'b0011010, busy};
        return {7'b1111000, busy};
    endfunction

    task automatic model_upd(int k);
        logic [7:0] o;
        if (!n_rst) begin
            age[k] = 0; pst[k] = 0; pfl[k] = 0;
        end else begin
            o = model_out(k);
            if (!o[7] && pst[k] < cmax[k]) pst[k]++;
            if ((|o[3:1]) && pfl[k] < cmax[k]) pfl[k]++;
            if (!mem) age[k] = (age[k] == 0) ? (start ? 1 : 0) : (age[k] == lat[k] - 1 ? 0 : age[k] + 1);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input logic [8:0] vexp);
        @(negedge clk);
        if (vexp[8]) chk({nm, " vec"}, out_a, vexp[7:0]);
        chk({nm, " a out"}, out_a, model_out(0));
        chk({nm, " b out"}, out_b, model_out(1));
        if (perf_ok) begin
            chk({nm, " a stall"}, ifa.o_perf_stall, pst[0]);
            chk({nm, " a flush"}, ifa.o_perf_flush, pfl[0]);
            chk({nm, " b stall"}, ifb.o_perf_stall, pst[1]);
            chk({nm, " b flush"}, ifb.o_perf_flush, pfl[1]);
        end
        @(posedge clk);
        if (!n_rst) perf_ok = 1;
        model_upd(0);
        model_upd(1);
        #1;
    endtask

    typedef struct {
        logic rn, mem, st, rd, ld;
        logic [4:0] erd, rs1, rs2;
        logic u1, u2;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    initial begin
        logic [63:0] p0, f0;
        {mem, start, redir, isld, u1, u2} = '0;
        {erd, rs1, rs2} = '0;
        n_rst = 1'b0;
        age = '{0, 0};
        // exp: {pc_en, en_fd, en_de, en_em, flush_fd, flush_de, flush_em, mc_busy} on MC_LAT=4
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000000}); // 0 reset
        vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b11110000}); // 1 idle
        vecs.push_back('{1, 0, 0, 0, 1, 5, 5, 0, 1, 0, 8'b00110100}); // 2 load-use rs1
        vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b11110000}); // 3 normal
        vecs.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 8'b11110000}); // 4 x0 never stalls
        vecs.push_back('{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'b00010010}); // 5 mc cycle 1
        vecs.push_back('{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'b00010011}); // 6 mc cycle 2
        vecs.push_back('{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'b00010011}); // 7 mc cycle 3
        vecs.push_back('{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'b11110001}); // 8 release
        vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b11110000}); // 9 normal
        vecs.push_back('{1, 0, 0, 1, 1, 7, 0, 7, 0, 1, 8'b11111100}); // 10 redirect over load-use
        vecs.push_back('{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'b00010010}); // 11 mc cycle 1
        vecs.push_back('{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 8'b00000001}); // 12 mem stall
        vecs.push_back('{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 8'b00000001}); // 13 mem stall
        vecs.push_back('{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'b00010011}); // 14 resume
        vecs.push_back('{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'b00010011}); // 15
        vecs.push_back('{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'b11110001}); // 16 release
        vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b11110000}); // 17 normal
        p0 = '0; f0 = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            {n_rst, mem, start, redir, isld} = {vecs[i].rn, vecs[i].mem, vecs[i].st, vecs[i].rd, vecs[i].ld};
            {erd, rs1, rs2, u1, u2} = {vecs[i].erd, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2};
            if (i == 10) f0 = ifa.o_perf_flush;
            if (i == 11) begin
                chk("redirect flush delta", ifa.o_perf_flush - f0, 1);
                p0 = ifa.o_perf_stall;
            end
            step($sformatf("vec%0d", i), {1'b1, vecs[i].exp});
        end
        chk("mc mem stall delta", ifa.o_perf_stall - p0, 5);

        // reset while BUSY with mc_cnt=1
        {mem, redir, isld, u1, u2} = '0;
        start = 1'b1;
        step("rb start", 9'b0);
        step("rb busy", 9'b0);
        n_rst = 1'b0;
        step("rb reset", {1'b1, 8'b0});
        n_rst = 1'b1;
        start = 1'b0;
        chk("rb stall cleared", ifa.o_perf_stall, 0);
        chk("rb flush cleared", ifa.o_perf_flush, 0);
        step("rb after", {1'b1, 8'b11110000});

        // saturation of the 4-bit counters
        n_rst = 1'b0;
        step("sat reset", 9'b0);
        n_rst = 1'b1;
        {isld, u1, erd, rs1} = {1'b1, 1'b1, 5'd3, 5'd3};
        for (int i = 0; i < 20; i++) step("sat lu", {1'b1, 8'b00110100});
        chk("sat b stall", ifb.o_perf_stall, 15);
        chk("sat b flush", ifb.o_perf_flush, 15);
        chk("sat a stall", ifa.o_perf_stall, 20);

        for (int i = 0; i < 600; i++) begin
            n_rst = ($urandom_range(0, 49) != 0);
            mem = ($urandom_range(0, 7) == 0);
            start = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 5) == 0);
            isld = ($urandom_range(0, 2) == 0);
            erd = 5'($urandom_range(0, 3));
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            u1 = 1'($urandom);
            u2 = 1'($urandom);
            step("rand", 9'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
